multichannel_comm: RTL and testbench
====================================

Name: multichannel_comm

Overview:
- Multiplexes 2^CHANNEL_BIT independent message channels over a single byte stream.
- Sits between client logic, such as a memory model or CPU bus bridge, and a byte-oriented UART block with FIFO-style handshakes.
- Outbound messages are framed as a header byte plus little-endian payload bytes and pushed to the UART.
- Inbound frames are reassembled and delivered per channel.

Parameters:
- CHANNEL_BIT, 1: channel index width; NCH = 2^CHANNEL_BIT channels; legal range 1..3.
- MESSAGE_BIT, 72: payload width per message; multiple of 8, at most 248; MSG_BYTES = MESSAGE_BIT/8.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- send_flag  out  1  pushes send_data into the UART TX FIFO this cycle
- send_data  out  8  byte to transmit
- recv_flag  out  1  pops the UART RX FIFO this cycle
- recv_data  in  8  head byte of the UART RX FIFO, valid while recvable=1
- sendable  in  1  UART TX FIFO not full
- recvable  in  1  UART RX FIFO not empty
- read_flag  in  NCH  per-channel acknowledge/pop of the inbound message
- read_msg  out  NCH*(5+MESSAGE_BIT)  per-channel {len[4:0], data}; channel c occupies slice c
- write_flag  in  NCH  per-channel enqueue of an outbound message
- write_msg  in  NCH*(5+MESSAGE_BIT)  per-channel {len[4:0], data}
- readable  out  NCH  inbound message available
- writable  out  NCH  outbound slot free

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high; all other logic is posedge CLK.
- Reset state:
  - all buffers empty; readable=0; writable=all ones; read_msg=0.
  - send_flag=0 and recv_flag=0.
  - TX and RX FSMs in IDLE.
- Frame format:
  - Header byte: [7:5] = channel, zero-padded above CHANNEL_BIT; [4:0] = len.
  - Header is followed by len payload bytes, data[7:0] first.
- Outbound buffer, one entry per channel:
  - Accept on an edge where write_flag[c]=1 and writable[c]=1; write_flag while writable=0 is ignored.
  - writable[c] drops on the next cycle and stays low until the last payload byte of that frame has been pushed.
- TX FSM (IDLE, HDR, DATA):
  - From IDLE, pick the lowest-index pending channel.
  - send_flag is combinational: (state is HDR or DATA) & sendable. send_data is the current byte.
  - The byte pointer advances only on edges where send_flag=1, so back-to-back bytes are allowed.
  - len=0 sends the header only.
  - After the last byte, return to IDLE; the next frame may start on the following cycle.
- RX FSM (HDR, DATA, HOLD):
  - recv_flag is combinational: (state is HDR or DATA) & recvable. A byte is consumed on edges where recv_flag=1.
  - HDR latches channel and len, clears the assembly register, then goes to DATA, or to HOLD if len=0.
  - DATA places byte i at data[8i+7:8i]; unreceived upper bytes are 0. After byte len, go to HOLD.
  - HOLD: if the target channel's inbound buffer is empty, transfer the message to it and go to HDR. Otherwise stall, with recv_flag=0, until that buffer is freed.
- Inbound buffer, one entry per channel:
  - readable[c] = valid[c] & ~read_flag[c] (combinational mask). This prevents a double read by clients that register read_flag.
  - The buffer is cleared on an edge with read_flag[c]=1.
  - read_msg[c] holds its value until cleared; afterwards the stale value may remain.
  - If a transfer and a clear for the same channel coincide, the clear wins and the transfer waits one cycle.
- Header for a channel index ≥ NCH: the frame is consumed and discarded.
- len > MSG_BYTES: all bytes are consumed, bytes beyond MSG_BYTES are dropped, and len is delivered clipped to MSG_BYTES.
- Reset mid-frame: any partial frame is lost and both FSMs return to the reset state.

Optional Feature:
- Macro MULTCHAN_FRAME_CHECK_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0, sticky until RST).
  - frame_err sets on a bad channel index or len > MSG_BYTES.
  - The offending frame is consumed entirely and not delivered.
- Undefined:
  - The port is absent.
  - Bad channel frames are discarded; over-long frames are clipped as in Behaviour.

Test Plan:
1. Channel 0 write len=5, data=0x00_0000_0001_0000_1000, sendable=1 → send_data 0x05,0x00,0x10,0x00,0x00,0x01 on 6 consecutive cycles; writable[0] high again after the last byte.
2. recvable stream 0x04,0xEF,0xBE,0xAD,0xDE → readable[0]=1 with len=4, data=0xDEADBEEF; read_flag[0] pulse → readable[0] falls the same cycle (mask) and stays 0.
3. Channels 0 and 1 written in the same cycle → channel 0 frame fully sent before channel 1 header 0x2?; no interleaving.
4. Toggle sendable=0 mid-frame → send_flag=0 while low, no byte lost or duplicated, correct order resumes.
5. Two frames for channel 1 arrive while read_flag is held low → second frame stalls in HOLD, recv_flag=0; after read_flag, second message delivered.
6. Assert RST mid-RX after 2 of 5 payload bytes → readable=0, writable all ones; next complete frame decoded correctly.

Source files
------------

// File: rtl/multichannel_comm_if.sv
// Handshake bundle for multichannel_comm: UART byte FIFO side plus per-channel client side.
// frame_err is present only when MULTCHAN_FRAME_CHECK_EN is defined.
interface multichannel_comm_if #(
  parameter int CHANNEL_BIT = 1,
  parameter int MESSAGE_BIT = 72
);
  localparam int NCH = 1 << CHANNEL_BIT;
  localparam int W   = 5 + MESSAGE_BIT;

  logic             send_flag;
  logic [7:0]       send_data;
  logic             recv_flag;
  logic [7:0]       recv_data;
  logic             sendable;
  logic             recvable;
  logic [NCH-1:0]   read_flag;
  logic [NCH*W-1:0] read_msg;
  logic [NCH-1:0]   write_flag;
  logic [NCH*W-1:0] write_msg;
  logic [NCH-1:0]   readable;
  logic [NCH-1:0]   writable;
  logic [1:0]       tx_state;
  logic [1:0]       rx_state;
`ifdef MULTCHAN_FRAME_CHECK_EN
  logic             frame_err;
`endif

  // Every transfer is a single-cycle strobe qualified by its status line:
  // send_flag only while sendable, recv_flag only while recvable,
  // write_flag counts only while writable, read_flag acknowledges readable.
  modport master (
`ifdef MULTCHAN_FRAME_CHECK_EN
    output frame_err,
`endif
    output send_flag, send_data, recv_flag, read_msg, readable, writable,
    output tx_state, rx_state,
    input  recv_data, sendable, recvable, read_flag, write_flag, write_msg
  );

  modport slave (
`ifdef MULTCHAN_FRAME_CHECK_EN
    input  frame_err,
`endif
    input  send_flag, send_data, recv_flag, read_msg, readable, writable,
    input  tx_state, rx_state,
    output recv_data, sendable, recvable, read_flag, write_flag, write_msg
  );
endinterface

// File: rtl/multichannel_comm.sv
// Multiplexes 2^CHANNEL_BIT message channels over one byte stream (header + LE payload).
// Optional MULTCHAN_FRAME_CHECK_EN: drop bad-channel/over-long frames and flag frame_err.
module multichannel_comm #(
  parameter int CHANNEL_BIT = 1,
  parameter int MESSAGE_BIT = 72
) (
  input logic                 CLK,
  input logic                 RST,
  multichannel_comm_if.master bus
);
  localparam int         NCH         = 1 << CHANNEL_BIT;
  localparam int         W           = 5 + MESSAGE_BIT;
  localparam int         MSG_BYTES   = MESSAGE_BIT / 8;
  localparam logic [4:0] MSG_BYTES_L = 5'(MSG_BYTES);

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA} tx_state_t;
  typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_HOLD} rx_state_t;

  // ---------------- outbound ----------------
  logic [NCH-1:0]         out_valid;
  logic [W-1:0]           out_msg [NCH];
  tx_state_t              tx_state, tx_next;
  logic [CHANNEL_BIT-1:0] tx_ch, tx_ch_next, tx_pick;
  logic [4:0]             tx_ptr, tx_ptr_next, tx_len;
  logic [MESSAGE_BIT-1:0] tx_data;
  logic [7:0]             tx_byte;
  logic                   tx_done;
  logic                   send_flag;
  logic [7:0]             send_data;

  always_comb begin
    tx_len  = out_msg[tx_ch][W-1 -: 5];
    tx_data = out_msg[tx_ch][MESSAGE_BIT-1:0];
    tx_byte = 8'h00;
    for (int i = 0; i < MSG_BYTES; i++)
      if (tx_ptr == 5'(i)) tx_byte = tx_data[8*i +: 8];
    // descending scan so the lowest pending index wins
    tx_pick = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (out_valid[c]) tx_pick = CHANNEL_BIT'(c);

    tx_next     = tx_state;
    tx_ch_next  = tx_ch;
    tx_ptr_next = tx_ptr;
    tx_done     = 1'b0;
    send_flag   = 1'b0;
    send_data   = 8'h00;
    case (tx_state)
      TX_IDLE: begin
        if (|out_valid) begin
          tx_ch_next = tx_pick;
          tx_next    = TX_HDR;
        end
      end
      TX_HDR: begin
        send_flag = bus.sendable;
        send_data = {3'(tx_ch), tx_len};
        if (bus.sendable) begin
          tx_ptr_next = '0;
          if (tx_len == 5'd0) begin
            tx_done = 1'b1;
            tx_next = TX_IDLE;
          end else begin
            tx_next = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        send_flag = bus.sendable;
        send_data = tx_byte;
        if (bus.sendable) begin
          if (tx_ptr == tx_len - 5'd1) begin
            tx_done = 1'b1;
            tx_next = TX_IDLE;
          end else begin
            tx_ptr_next = tx_ptr + 5'd1;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_ch    <= '0;
      tx_ptr   <= '0;
    end else begin
      tx_state <= tx_next;
      tx_ch    <= tx_ch_next;
      tx_ptr   <= tx_ptr_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= '0;
      for (int c = 0; c < NCH; c++) out_msg[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (tx_done && tx_ch == CHANNEL_BIT'(c)) begin
          out_valid[c] <= 1'b0;
        end else if (bus.write_flag[c] && !out_valid[c]) begin
          out_valid[c] <= 1'b1;
          out_msg[c]   <= bus.write_msg[c*W +: W];
        end
      end
    end
  end

  // ---------------- inbound ----------------
  rx_state_t              rx_state, rx_next;
  logic [CHANNEL_BIT-1:0] rx_ch;
  logic [4:0]             rx_len, rx_cnt, rx_len_clip;
  logic                   rx_drop, hdr_drop, hdr_bad_ch;
  logic [MESSAGE_BIT-1:0] rx_asm;
  logic                   rx_xfer, tgt_free, recv_flag;
  logic [NCH-1:0]         in_valid;
  logic [W-1:0]           in_msg [NCH];
`ifdef MULTCHAN_FRAME_CHECK_EN
  logic                   hdr_long;
  logic                   frame_err;
`endif

  always_comb begin
    hdr_bad_ch = ({1'b0, bus.recv_data[7:5]} >= 4'(NCH));
`ifdef MULTCHAN_FRAME_CHECK_EN
    hdr_long = (bus.recv_data[4:0] > MSG_BYTES_L);
    hdr_drop = hdr_bad_ch | hdr_long;
`else
    hdr_drop = hdr_bad_ch;
`endif
    rx_len_clip = (rx_len > MSG_BYTES_L) ? MSG_BYTES_L : rx_len;
    // a clear on the same edge wins; the transfer retries next cycle
    tgt_free  = ~in_valid[rx_ch] & ~bus.read_flag[rx_ch];
    rx_next   = rx_state;
    rx_xfer   = 1'b0;
    recv_flag = 1'b0;
    case (rx_state)
      RX_HDR: begin
        recv_flag = bus.recvable;
        if (bus.recvable)
          rx_next = (bus.recv_data[4:0] == 5'd0) ? RX_HOLD : RX_DATA;
      end
      RX_DATA: begin
        recv_flag = bus.recvable;
        if (bus.recvable && rx_cnt == rx_len - 5'd1) rx_next = RX_HOLD;
      end
      RX_HOLD: begin
        if (rx_drop) begin
          rx_next = RX_HDR;
        end else if (tgt_free) begin
          rx_xfer = 1'b1;
          rx_next = RX_HDR;
        end
      end
      default: rx_next = RX_HDR;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state <= RX_HDR;
      rx_ch    <= '0;
      rx_len   <= '0;
      rx_cnt   <= '0;
      rx_drop  <= 1'b0;
      rx_asm   <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_HDR && recv_flag) begin
        rx_ch   <= bus.recv_data[5 +: CHANNEL_BIT];
        rx_len  <= bus.recv_data[4:0];
        rx_cnt  <= '0;
        rx_drop <= hdr_drop;
        rx_asm  <= '0;
      end else if (rx_state == RX_DATA && recv_flag) begin
        rx_cnt <= rx_cnt + 5'd1;
        for (int i = 0; i < MSG_BYTES; i++)
          if (rx_cnt == 5'(i)) rx_asm[8*i +: 8] <= bus.recv_data;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_valid <= '0;
      for (int c = 0; c < NCH; c++) in_msg[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.read_flag[c]) begin
          in_valid[c] <= 1'b0;
        end else if (rx_xfer && rx_ch == CHANNEL_BIT'(c)) begin
          in_valid[c] <= 1'b1;
          in_msg[c]   <= {rx_len_clip, rx_asm};
        end
      end
    end
  end

`ifdef MULTCHAN_FRAME_CHECK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) frame_err <= 1'b0;
    else if (rx_state == RX_HDR && recv_flag && hdr_drop) frame_err <= 1'b1;
  end
  assign bus.frame_err = frame_err;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_rd
    assign bus.read_msg[g*W +: W] = in_msg[g];
  end

  assign bus.readable  = in_valid & ~bus.read_flag;
  assign bus.writable  = ~out_valid;
  assign bus.send_flag = send_flag;
  assign bus.send_data = send_data;
  assign bus.recv_flag = recv_flag;
  assign bus.tx_state  = tx_state;
  assign bus.rx_state  = rx_state;
endmodule

// File: tb/tb_multichannel_comm.sv
// Directed bench for multichannel_comm: frame-level model of the TX byte stream and the
// per-channel delivered messages, checked by one compare process on every falling edge.
module tb_multichannel_comm;
  localparam int CHANNEL_BIT = 1;
  localparam int MESSAGE_BIT = 72;
  localparam int NCH         = 2;
  localparam int W           = 5 + MESSAGE_BIT;
  localparam int MSG_BYTES   = MESSAGE_BIT / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multichannel_comm_if #(.CHANNEL_BIT(CHANNEL_BIT), .MESSAGE_BIT(MESSAGE_BIT)) bus ();
  multichannel_comm #(.CHANNEL_BIT(CHANNEL_BIT), .MESSAGE_BIT(MESSAGE_BIT)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.master)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  logic [7:0]   exp_tx_q [$];
  logic [W-1:0] exp_rx_q [NCH][$];
  logic [7:0]   rx_fifo [$];
  logic [7:0]   bq [$];
  int           send_cycles [$];
  logic         take_rx = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- UART RX FIFO model ----------------
  always @(posedge clk) begin
    cyc++;
    #1;
    if (take_rx && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
    bus.recvable  = (rx_fifo.size() > 0);
    bus.recv_data = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
  end

  // ---------------- frame-level model ----------------
  task automatic model_tx(input int c, input logic [4:0] len, input logic [MESSAGE_BIT-1:0] data);
    logic [2:0] ch3;
    ch3 = c[2:0];
    exp_tx_q.push_back({ch3, len});
    for (int k = 0; k < int'(len); k++)
      exp_tx_q.push_back((k < MSG_BYTES) ? data[8*k +: 8] : 8'h00);
  endtask

  // Parses the frames in bq into expected deliveries, then feeds bq to the RX FIFO.
  task automatic rx_send();
    int                     i;
    logic [2:0]             ch;
    logic [4:0]             len, lenc;
    logic [MESSAGE_BIT-1:0] data;
    logic                   ok;
    i = 0;
    while (i < bq.size()) begin
      ch = bq[i][7:5];
      len = bq[i][4:0];
      i++;
      data = '0;
      for (int k = 0; k < int'(len); k++)
        if (k < MSG_BYTES) data[8*k +: 8] = bq[i+k];
      i += int'(len);
      ok = (int'(ch) < NCH);
`ifdef MULTCHAN_FRAME_CHECK_EN
      ok = ok && (int'(len) <= MSG_BYTES);
`endif
      lenc = (int'(len) > MSG_BYTES) ? 5'(MSG_BYTES) : len;
      if (ok) exp_rx_q[ch[0]].push_back({lenc, data});
    end
    foreach (bq[j]) rx_fifo.push_back(bq[j]);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      take_rx = 1'b0;
    end else begin
      take_rx = bus.recv_flag;
      if (bus.send_flag) begin
        send_cycles.push_back(cyc);
        if (exp_tx_q.size() == 0) check("tx_unexpected", bus.send_flag, 1'b0);
        else check("tx_byte", bus.send_data, exp_tx_q.pop_front());
      end
      if (!bus.sendable && exp_tx_q.size() > 0) check("tx_stall", bus.send_flag, 1'b0);
      if (!bus.recvable) check("rx_pop_empty", bus.recv_flag, 1'b0);
      for (int c = 0; c < NCH; c++) begin
        if (bus.readable[c]) begin
          if (exp_rx_q[c].size() == 0) check("rx_unexpected", bus.readable[c], 1'b0);
          else check("rx_msg", bus.read_msg[c*W +: W], exp_rx_q[c][0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_wr(input int c, input logic [4:0] len, input logic [MESSAGE_BIT-1:0] data);
    bus.write_flag[c]       = 1'b1;
    bus.write_msg[c*W +: W] = {len, data};
  endtask

  task automatic commit_wr();
    @(posedge clk); #1;
    bus.write_flag = '0;
  endtask

  task automatic wait_tx_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #2;
      if (exp_tx_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("tx_drain", done, 1'b1);
  endtask

  task automatic read_ch(input int c, input logic [W-1:0] lit);
    bit got;
    got = 1'b0;
    if (exp_rx_q[c].size() > 0) check("model_pin", exp_rx_q[c][0], lit);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.readable[c]) begin
        got = 1'b1;
        break;
      end
    end
    check("rd_wait", got, 1'b1);
    if (!got) return;
    check("rd_msg", bus.read_msg[c*W +: W], lit);
    @(posedge clk); #1;
    bus.read_flag[c] = 1'b1;
    #1;
    check("rd_mask", bus.readable[c], 1'b0);
    if (exp_rx_q[c].size() > 0) void'(exp_rx_q[c].pop_front());
    @(posedge clk); #1;
    bus.read_flag[c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [19:0] pat;
    bit          ok;
    bus.sendable   = 1'b1;
    bus.read_flag  = '0;
    bus.write_flag = '0;
    bus.write_msg  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readable", bus.readable, 2'b00);
    check("rst_writable", bus.writable, 2'b11);
    check("rst_read_msg", bus.read_msg, '0);
    check("rst_send_flag", bus.send_flag, 1'b0);
    check("rst_recv_flag", bus.recv_flag, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;

    // 1: single frame, back-to-back bytes
    send_cycles.delete();
    @(posedge clk); #1;
    set_wr(0, 5'd5, 72'h00_0000_0001_0000_1000);
    commit_wr();
    model_tx(0, 5'd5, 72'h00_0000_0001_0000_1000);
    check("t1_hdr_pin", exp_tx_q[0], 8'h05);
    check("t1_b1_pin", exp_tx_q[2], 8'h10);
    check("t1_b4_pin", exp_tx_q[5], 8'h01);
    @(negedge clk);
    check("t1_writable_low", bus.writable[0], 1'b0);
    wait_tx_drain();
    check("t1_writable_back", bus.writable[0], 1'b1);
    check("t1_nbytes", send_cycles.size(), 6);
    if (send_cycles.size() == 6) check("t1_span", send_cycles[5] - send_cycles[0], 5);

    // 2: inbound frame, read mask
    bq = {8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rx_send();
    read_ch(0, {5'd4, 72'hDEAD_BEEF});
    @(negedge clk);
    check("t2_stays_low", bus.readable[0], 1'b0);

    // 3: two channels written together, lowest index first, no interleave
    @(posedge clk); #1;
    set_wr(0, 5'd2, 72'hB2B1);
    set_wr(1, 5'd3, 72'hC3C2C1);
    commit_wr();
    model_tx(0, 5'd2, 72'hB2B1);
    model_tx(1, 5'd3, 72'hC3C2C1);
    check("t3_hdr0_pin", exp_tx_q[0], 8'h02);
    check("t3_hdr1_pin", exp_tx_q[3], 8'h23);
    wait_tx_drain();

    // 4: sendable toggling mid-frame, then a header-only frame
    @(posedge clk); #1;
    set_wr(1, 5'd4, 72'h4433_2211);
    commit_wr();
    model_tx(1, 5'd4, 72'h4433_2211);
    pat = 20'b1101_0011_1001_0100_0110;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.sendable = pat[i];
    end
    @(posedge clk); #1;
    bus.sendable = 1'b1;
    wait_tx_drain();
    @(posedge clk); #1;
    set_wr(1, 5'd0, 72'h0);
    commit_wr();
    model_tx(1, 5'd0, 72'h0);
    check("t4_len0_pin", exp_tx_q[0], 8'h20);
    wait_tx_drain();

    // 5: second ch1 frame stalls in HOLD while the buffer is full
    bq = {8'h22, 8'hAA, 8'hBB, 8'h21, 8'hCC, 8'h01, 8'h77};
    rx_send();
    repeat (30) @(negedge clk);
    check("t5_readable", bus.readable[1], 1'b1);
    check("t5_recvable", bus.recvable, 1'b1);
    check("t5_stall", bus.recv_flag, 1'b0);
    check("t5_fifo_left", rx_fifo.size(), 2);
    read_ch(1, {5'd2, 72'hBBAA});
    read_ch(1, {5'd1, 72'hCC});
    read_ch(0, {5'd1, 72'h77});

    // clip over-long frame, discard bad channel, len 0 delivery
    bq = {8'h0B};
    for (int k = 1; k <= 11; k++) bq.push_back(8'(k));
    bq.push_back(8'h41); bq.push_back(8'h99);
    bq.push_back(8'h20);
    bq.push_back(8'h21); bq.push_back(8'h5A);
    rx_send();
`ifndef MULTCHAN_FRAME_CHECK_EN
    read_ch(0, {5'd9, 72'h09_0807_0605_0403_0201});
`endif
    read_ch(1, {5'd0, 72'h0});
    read_ch(1, {5'd1, 72'h5A});

    // 6: reset mid-frame on both sides
    @(posedge clk); #1;
    bus.sendable = 1'b0;
    set_wr(0, 5'd3, 72'h030201);
    commit_wr();
    bq = {8'h05, 8'h01, 8'h02};
    foreach (bq[j]) rx_fifo.push_back(bq[j]);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rx_fifo.size() == 0 && !bus.recvable) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_partial_taken", ok, 1'b1);
    check("t6_pending_tx", bus.writable[0], 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    rx_fifo.delete();
    repeat (2) @(negedge clk);
    check("t6_rst_readable", bus.readable, 2'b00);
    check("t6_rst_writable", bus.writable, 2'b11);
    check("t6_rst_send_flag", bus.send_flag, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    bus.sendable = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_post_writable", bus.writable, 2'b11);
    check("t6_post_readable", bus.readable, 2'b00);
    bq = {8'h03, 8'h11, 8'h22, 8'h33};
    rx_send();
    read_ch(0, {5'd3, 72'h33_2211});

    repeat (5) @(posedge clk);
    check("end_tx_left", exp_tx_q.size(), 0);
    for (int c = 0; c < NCH; c++) check("end_rx_left", exp_rx_q[c].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
